control_unit: RTL
=================

# control_unit

Multicycle main control FSM of the processor datapath. It decodes opcode/funct from the instruction register, sequences fetch/decode/execute/memory/write-back, and drives every datapath enable and mux select. This includes the 3-bit select of the PC-source selector directly downstream. That selector registers its output on the clock edge, so this block presents `pc_source` one cycle before the cycle in which it asserts `pc_write`.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instruction bits [31:26] from the IR.
- `funct`  in  6  instruction bits [5:0] from the IR.
- `zero`  in  1  ALU zero flag, combinational from the current ALU operation.
- `pc_write`  out  1  PC register load enable.
- `pc_source`  out  3  PC-source selector input:
  - 000 = ALU result (PC+4)
  - 001 = ALUOut (branch target)
  - 010 = jump target
  - 011 = register A (jr)
  - 100 = exception vector
  - 101–111 are never driven.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  IR load enable.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- `mem_to_reg`  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`  out  3  ALU operation: 001 add, 010 sub, 011 and, 100 slt.
- `epc_write`  out  1  EPC load enable; EPC captures the current PC.

## Operation
- Moore FSM: outputs are decoded from the state register only. Any output not listed for a state is 0.
- `zero_q` is a 1-bit register that captures `zero` at the end of BRANCH.
- Reset: while `reset` is high at a clock edge, the state goes to RESET and `zero_q` clears to 0. This holds regardless of the current state, including mid-instruction; there is no partial write-back afterwards.
- RESET: all outputs 0. Next state FETCH.
- FETCH: `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add, `pc_source`=000. Next FETCH_WAIT.
- FETCH_WAIT: `ir_write`=1, `pc_write`=1. Next DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=add (branch target into ALUOut). Next state by `opcode`/`funct`:
  - R-type (opcode 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x2A slt → EXEC_R.
  - R-type with funct 0x08 jr → JR_SEL.
  - 0x23 lw, 0x2B sw → ADDR.
  - 0x04 beq, 0x05 bne → BRANCH.
  - 0x02 j → JUMP_SEL.
  - 0x03 jal → JAL_LINK.
  - 0x08 addi → EXEC_I.
  - Any other opcode, or opcode 0x00 with any other funct → EXC_SEL.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct. Next WB_R.
- WB_R: `reg_write`=1, `reg_dst`=01, `mem_to_reg`=00. Next FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add. Next WB_I.
- WB_I: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=00. Next FETCH.
- ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `iord`=1. Next MEM_WAIT.
- MEM_WAIT: `iord`=1. Next WB_LW.
- WB_LW: `reg_write`=1, `reg_dst`=00, `mem_to_reg`=01. Next FETCH.
- MEM_WR: `iord`=1, `mem_write`=1. Next FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_source`=001; `zero_q` is loaded from `zero`. Next BR_WR.
- BR_WR: `pc_write` = (beq & `zero_q`) | (bne & !`zero_q`). Opcode is read from the IR, which is stable here. Next FETCH.
- JAL_LINK: `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. PC already holds PC+4, so that value is the link address. Next JUMP_SEL.
- JUMP_SEL: `pc_source`=010. Next JUMP_WR.
- JUMP_WR: `pc_write`=1. Next FETCH.
- JR_SEL: `pc_source`=011. Next JR_WR.
- JR_WR: `pc_write`=1. Next FETCH.
- EXC_SEL: `pc_source`=100. Next EXC_WR.
- EXC_WR: `pc_write`=1, `epc_write`=1. EPC holds PC+4 of the faulting instruction. Next FETCH.

## Timing
- Reset values: state RESET, every output 0, `zero_q`=0.
- The first FETCH is in the cycle after `reset` deasserts.
- Every `pc_write` pulse is exactly 1 cycle and is immediately preceded by exactly 1 cycle with the matching `pc_source` held.
- Instruction latencies, counted from FETCH to the last state inclusive:
  - 5 cycles: R-type, addi, sw, beq/bne, j, jr, exception.
  - 6 cycles: jal.
  - 7 cycles: lw.
- `mem_write`, `reg_write`, `ir_write` and `epc_write` are single-cycle pulses, at most one write-back per instruction.
- A `zero` change in any state other than BRANCH has no effect.

## Test plan
- Reset → outputs: hold `reset` for 2 cycles with `opcode` = 0x23. Required: all outputs 0 throughout; FETCH (`pc_source`=000, `alu_src_b`=01) in the first cycle after release.
- R-type add: `opcode` 0x00, `funct` 0x20. Required sequence FETCH, FETCH_WAIT (`pc_write`=1, `ir_write`=1), DECODE, EXEC_R (`alu_op`=001), WB_R (`reg_write`=1, `reg_dst`=01), then FETCH on cycle 6.
- beq, taken and not taken: `opcode` 0x04. With `zero`=1 in BRANCH, BR_WR shows `pc_write`=1 and the prior cycle shows `pc_source`=001. With `zero`=0 in BRANCH and `zero` toggled to 1 in BR_WR, `pc_write` stays 0. Repeat with bne (0x05) and expect the inverse result.
- lw then sw: lw shows `iord`=1 for 2 cycles and `reg_write` with `mem_to_reg`=01 on cycle 7. sw shows `mem_write`=1 on cycle 5 only.
- jal then jr: jal shows `reg_write` with `reg_dst`=10, `mem_to_reg`=10, then `pc_source`=010, then `pc_write`. jr (`funct` 0x08) shows `pc_source`=011 then `pc_write`.
- Illegal opcode 0x3F, then reset mid-lw: 0x3F gives `pc_source`=100 then `pc_write`=1 with `epc_write`=1. Asserting `reset` in MEM_WAIT gives no `reg_write` pulse and restarts at FETCH after release.

Source files
------------

// File: rtl/control_unit.sv
// control_unit
//   Multicycle main control FSM. Decodes opcode/funct from the IR, steps through
//   fetch / decode / execute / memory / write-back and drives every datapath
//   enable and mux select. The PC-source selector downstream registers its input,
//   so pc_source is presented one state before the state that pulses pc_write.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode, funct   IR[31:26], IR[5:0]
//   zero            ALU zero flag (sampled only at the end of BRANCH)
//   pc_write        PC load enable
//   pc_source[2:0]  000 PC+4, 001 ALUOut, 010 jump target, 011 reg A, 100 exc vector
//   iord            memory address: 0 PC, 1 ALUOut
//   mem_write       memory write strobe
//   ir_write        IR load enable
//   reg_write       register file write enable
//   reg_dst[1:0]    00 rt, 01 rd, 10 r31
//   mem_to_reg[1:0] 00 ALUOut, 01 MDR, 10 PC
//   alu_src_a       0 PC, 1 reg A
//   alu_src_b[1:0]  00 reg B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   alu_op[2:0]     001 add, 010 sub, 011 and, 100 slt
//   epc_write       EPC load enable
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic [2:0] pc_source,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       epc_write
);

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE,
        S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_ADDR, S_MEM_RD, S_MEM_WAIT, S_WB_LW, S_MEM_WR,
        S_BRANCH, S_BR_WR, S_JAL_LINK, S_JUMP_SEL, S_JUMP_WR,
        S_JR_SEL, S_JR_WR, S_EXC_SEL, S_EXC_WR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    state_t state_q, state_d;
    logic   zero_q, zero_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        // zero is only meaningful while BRANCH has the ALU doing A - B
        zero_d  = (state_q == S_BRANCH) ? zero : zero_q;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = S_EXEC_R;
                            FN_JR:                          state_d = S_JR_SEL;
                            default:                        state_d = S_EXC_SEL;
                        endcase
                    end
                    OP_LW, OP_SW:   state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP_SEL;
                    OP_JAL:         state_d = S_JAL_LINK;
                    OP_ADDI:        state_d = S_EXEC_I;
                    default:        state_d = S_EXC_SEL;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_ADDR:     state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WAIT;
            S_MEM_WAIT: state_d = S_WB_LW;
            S_WB_LW:    state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_BR_WR;
            S_BR_WR:    state_d = S_FETCH;
            S_JAL_LINK: state_d = S_JUMP_SEL;
            S_JUMP_SEL: state_d = S_JUMP_WR;
            S_JUMP_WR:  state_d = S_FETCH;
            S_JR_SEL:   state_d = S_JR_WR;
            S_JR_WR:    state_d = S_FETCH;
            S_EXC_SEL:  state_d = S_EXC_WR;
            S_EXC_WR:   state_d = S_FETCH;
            default:    state_d = S_RESET;
        endcase
    end

    // Output decode; EXEC_R and BR_WR also look at the IR, which is stable there
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 3'b000;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        epc_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
            end
            S_FETCH_WAIT: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = 3'b000;
                endcase
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_WB_I: reg_write = 1'b1;
            S_MEM_RD, S_MEM_WAIT: iord = 1'b1;
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 3'b001;
            end
            S_BR_WR: pc_write = ((opcode == OP_BEQ) &  zero_q) |
                                ((opcode == OP_BNE) & ~zero_q);
            S_JAL_LINK: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            S_JUMP_SEL: pc_source = 3'b010;
            S_JR_SEL:   pc_source = 3'b011;
            S_EXC_SEL:  pc_source = 3'b100;
            S_JUMP_WR, S_JR_WR: pc_write = 1'b1;
            S_EXC_WR: begin
                pc_write  = 1'b1;
                epc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
